// File: rtl/vga_box_painter.sv
// Bouncing solid-box pixel generator: 2-stage colour pipeline with syncs/display-enable
// delayed alongside, plus a per-frame position/direction update during vertical blanking.
module vga_box_painter #(
    parameter int N        = 9,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_W    = 64,
    parameter int BOX_H    = 48,
    parameter int STEP     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N:0]   horiz_count,
    input  logic [N:0]   vert_count,
    input  logic         horiz_sync_in,
    input  logic         vert_sync_in,
    input  logic         display_en_in,
    input  logic         pause,
    input  logic [23:0]  box_color,
    input  logic [23:0]  bg_color,
    output logic [7:0]   R,
    output logic [7:0]   G,
    output logic [7:0]   B,
    output logic         horiz_sync_out,
    output logic         vert_sync_out,
    output logic         display_en_out,
    output logic [N:0]   box_x,
    output logic [N:0]   box_y,
    output logic         frame_tick
);

    localparam int X_LIM_I = H_ACTIVE - BOX_W;
    localparam int Y_LIM_I = V_ACTIVE - BOX_H;
    localparam logic [N:0] X_LIMIT  = X_LIM_I[N:0];
    localparam logic [N:0] Y_LIMIT  = Y_LIM_I[N:0];
    localparam logic [N:0] BOX_W_C  = BOX_W[N:0];
    localparam logic [N:0] BOX_H_C  = BOX_H[N:0];
    localparam logic [N:0] STEP_C   = STEP[N:0];
    localparam logic [N:0] V_ACT_C  = V_ACTIVE[N:0];

    // One axis of the bounce: returns {dir, pos}.
    function automatic logic [N+1:0] step_axis(input logic [N:0] pos, input logic dir,
                                               input logic [N:0] limit);
        logic [N+1:0] nxt;
        nxt = {1'b0, pos} + {1'b0, STEP_C};
        if (!dir) begin
            if (nxt >= {1'b0, limit}) step_axis = {1'b1, limit};
            else                      step_axis = {1'b0, nxt[N:0]};
        end else begin
            if (pos <= STEP_C)        step_axis = '0;
            else                      step_axis = {1'b1, pos - STEP_C};
        end
    endfunction

    logic [N:0]  box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic        cond_q, cond_d, tick_q, tick_d;

    logic [N:0]  hdiff, vdiff;
    logic        inside_d;
    logic        inside_p1_q, hs_p1_q, vs_p1_q, vld_p1_q;
    logic [23:0] box_col_p1_q, bg_col_p1_q;
    logic [23:0] rgb_d, rgb_p2_q;
    logic        hs_p2_q, vs_p2_q, vld_p2_q;

    // Stage 1: box hit test against the current position, no wrap below the corner
    always_comb begin
        hdiff    = horiz_count - box_x_q;
        vdiff    = vert_count - box_y_q;
        inside_d = (horiz_count >= box_x_q) && (hdiff < BOX_W_C) &&
                   (vert_count >= box_y_q) && (vdiff < BOX_H_C);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inside_p1_q <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            vld_p1_q    <= 1'b0;
        end else begin
            inside_p1_q <= inside_d;
            hs_p1_q     <= horiz_sync_in;
            vs_p1_q     <= vert_sync_in;
            vld_p1_q    <= display_en_in;
        end
    end

    always_ff @(posedge clk) begin
        box_col_p1_q <= box_color;
        bg_col_p1_q  <= bg_color;
    end

    // Stage 2: colour select
    always_comb begin
        rgb_d = '0;
        if (vld_p1_q) rgb_d = inside_p1_q ? box_col_p1_q : bg_col_p1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_p2_q <= '0;
            hs_p2_q  <= 1'b1;
            vs_p2_q  <= 1'b1;
            vld_p2_q <= 1'b0;
        end else begin
            rgb_p2_q <= rgb_d;
            hs_p2_q  <= hs_p1_q;
            vs_p2_q  <= vs_p1_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    // Frame update: rising edge of the blanking condition, one move per frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            box_x_q <= '0;
            box_y_q <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
            cond_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            cond_q  <= cond_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        cond_d  = (vert_count == V_ACT_C) && (horiz_count == '0);
        tick_d  = cond_d && !cond_q;
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (tick_d && !pause) begin
            {dir_x_d, box_x_d} = step_axis(box_x_q, dir_x_q, X_LIMIT);
            {dir_y_d, box_y_d} = step_axis(box_y_q, dir_y_q, Y_LIMIT);
        end
    end

    always_comb begin
        R              = rgb_p2_q[7:0];
        G              = rgb_p2_q[15:8];
        B              = rgb_p2_q[23:16];
        horiz_sync_out = hs_p2_q;
        vert_sync_out  = vs_p2_q;
        display_en_out = vld_p2_q;
        box_x          = box_x_q;
        box_y          = box_y_q;
        frame_tick     = tick_q;
    end

endmodule

// File: tb/tb_vga_box_painter.sv
// Bench for vga_box_painter: table-driven pixel vectors through a scoreboard queue,
// plus hand-written sequences for reset, frame updates, pause and bouncing.
module tb_vga_box_painter;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic [N:0]   horiz_count, vert_count;
    logic         horiz_sync_in, vert_sync_in, display_en_in, pause;
    logic [23:0]  box_color, bg_color;
    logic [7:0]   R, G, B;
    logic         horiz_sync_out, vert_sync_out, display_en_out;
    logic [N:0]   box_x, box_y;
    logic         frame_tick;

    vga_box_painter dut (
        .clk(clk), .reset(reset),
        .horiz_count(horiz_count), .vert_count(vert_count),
        .horiz_sync_in(horiz_sync_in), .vert_sync_in(vert_sync_in),
        .display_en_in(display_en_in), .pause(pause),
        .box_color(box_color), .bg_color(bg_color),
        .R(R), .G(G), .B(B),
        .horiz_sync_out(horiz_sync_out), .vert_sync_out(vert_sync_out),
        .display_en_out(display_en_out),
        .box_x(box_x), .box_y(box_y), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [N:0] h, v;
        logic       de, hs, vs;
        logic [7:0] r, g, b;
    } vec_t;

    vec_t tbl[10];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tick_cnt = 0;
    int   base;

    always @(posedge clk) if (frame_tick === 1'b1) tick_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic compare_front();
        vec_t e;
        e = sb_q.pop_front();
        chk($sformatf("px%0d_rgb", e.id), {8'h0, B, G, R}, {8'h0, e.b, e.g, e.r});
        chk($sformatf("px%0d_sync", e.id), {29'h0, display_en_out, vert_sync_out, horiz_sync_out},
            {29'h0, e.de, e.vs, e.hs});
    endtask

    task automatic cycle_sb(input bit drain);
        @(posedge clk); #1;
        if (sb_q.size() == 2 || (drain && sb_q.size() == 1)) compare_front();
    endtask

    task automatic drive_vec(input vec_t t);
        horiz_count = t.h; vert_count = t.v;
        display_en_in = t.de; horiz_sync_in = t.hs; vert_sync_in = t.vs;
        sb_q.push_back(t);
        cycle_sb(1'b0);
    endtask

    task automatic idle_inputs();
        horiz_count = 10'd1; vert_count = 10'd0;
        display_en_in = 1'b0; horiz_sync_in = 1'b1; vert_sync_in = 1'b1;
    endtask

    task automatic do_update();
        vert_count = 10'd480; horiz_count = 10'd0;
        @(posedge clk); #1;
        vert_count = 10'd0; horiz_count = 10'd1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Box at (0,0): box_color 24'hFF0000 -> B=FF, bg 24'h00FF00 -> G=FF
        tbl[0] = '{0, 10'd10,  10'd10,  1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF};
        tbl[1] = '{1, 10'd100, 10'd10,  1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00};
        tbl[2] = '{2, 10'd63,  10'd47,  1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF};
        tbl[3] = '{3, 10'd64,  10'd47,  1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00};
        tbl[4] = '{4, 10'd63,  10'd48,  1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00};
        tbl[5] = '{5, 10'd10,  10'd10,  1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
        tbl[6] = '{6, 10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF};
        tbl[7] = '{7, 10'd5,   10'd50,  1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00};
        tbl[8] = '{8, 10'd200, 10'd300, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00};
        tbl[9] = '{9, 10'd30,  10'd20,  1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};

        box_color = 24'hFF0000; bg_color = 24'h00FF00; pause = 1'b0;
        reset = 1'b0;

        // Reset with random inputs for 3 cycles
        for (int i = 0; i < 3; i++) begin
            horiz_count   = 10'($urandom_range(0, 799));
            vert_count    = 10'($urandom_range(0, 524));
            horiz_sync_in = 1'($urandom);
            vert_sync_in  = 1'($urandom);
            display_en_in = 1'($urandom);
            pause         = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_rgb", {8'h0, R, G, B}, 32'h0);
        chk("rst_sync", {29'h0, horiz_sync_out, vert_sync_out, display_en_out}, 32'h6);
        chk("rst_box_x", {22'h0, box_x}, 32'd0);
        chk("rst_box_y", {22'h0, box_y}, 32'd0);
        chk("rst_tick", {31'h0, frame_tick}, 32'd0);

        // Pixel table straight out of reset
        reset = 1'b1; pause = 1'b0;
        for (int i = 0; i < 10; i++) drive_vec(tbl[i]);
        idle_inputs();
        cycle_sb(1'b1);
        chk("sb_empty", sb_q.size(), 32'd0);

        // Condition held 5 cycles: one tick, one move
        base = tick_cnt;
        vert_count = 10'd480; horiz_count = 10'd0;
        repeat (5) begin @(posedge clk); #1; end
        idle_inputs();
        repeat (2) begin @(posedge clk); #1; end
        chk("hold_ticks", tick_cnt - base, 32'd1);
        chk("hold_box_x", {22'h0, box_x}, 32'd2);
        chk("hold_box_y", {22'h0, box_y}, 32'd2);

        // Same with pause: tick still pulses, position holds
        base = tick_cnt;
        pause = 1'b1;
        vert_count = 10'd480; horiz_count = 10'd0;
        repeat (5) begin @(posedge clk); #1; end
        idle_inputs();
        repeat (2) begin @(posedge clk); #1; end
        pause = 1'b0;
        chk("pause_ticks", tick_cnt - base, 32'd1);
        chk("pause_box_x", {22'h0, box_x}, 32'd2);
        chk("pause_box_y", {22'h0, box_y}, 32'd2);

        // Bounce from a clean reset
        reset = 1'b0; @(posedge clk); #1; @(posedge clk); #1;
        reset = 1'b1;
        base = tick_cnt;
        for (int i = 0; i < 289; i++) begin
            do_update();
            if (i == 0) chk("first_upd_x", {22'h0, box_x}, 32'd2);
            if (i == 215) chk("bounce_y_top", {22'h0, box_y}, 32'd432);
            if (i == 216) chk("bounce_y_back", {22'h0, box_y}, 32'd430);
            if (i == 287) chk("bounce_x_top", {22'h0, box_x}, 32'd576);
        end
        chk("bounce_x_back", {22'h0, box_x}, 32'd574);
        chk("bounce_ticks", tick_cnt - base, 32'd289);

        for (int i = 0; i < 137; i++) do_update();
        chk("mid_box_x", {22'h0, box_x}, 32'd300);

        // Reset mid-bounce clears position and direction
        reset = 1'b0; @(posedge clk); #1;
        chk("midrst_box_x", {22'h0, box_x}, 32'd0);
        chk("midrst_box_y", {22'h0, box_y}, 32'd0);
        chk("midrst_tick", {31'h0, frame_tick}, 32'd0);
        reset = 1'b1;
        do_update();
        chk("post_rst_x", {22'h0, box_x}, 32'd2);
        chk("post_rst_y", {22'h0, box_y}, 32'd2);

        // Condition already true when reset releases counts as a new edge
        vert_count = 10'd480; horiz_count = 10'd0;
        reset = 1'b0; @(posedge clk); #1;
        reset = 1'b1; @(posedge clk); #1;
        chk("rel_tick", {31'h0, frame_tick}, 32'd1);
        chk("rel_box_x", {22'h0, box_x}, 32'd2);
        @(posedge clk); #1;
        chk("rel_tick_once", {31'h0, frame_tick}, 32'd0);
        chk("rel_box_x_hold", {22'h0, box_x}, 32'd2);
        idle_inputs();
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
